// File: rtl/sonic_irq_coalescer_if.sv
// Writeback and MSI request/acknowledge bundle between the coalescer and the host-side engines.
// Each request is level-held by the master until the matching ack is sampled.
interface sonic_irq_coalescer_if;
  logic        wb_req;
  logic        wb_ack;
  logic [63:0] wb_addr;
  logic [63:0] wb_data;
  logic        app_msi_req;
  logic        app_msi_ack;
  logic [4:0]  app_msi_num;

  modport master (
    output wb_req, wb_addr, wb_data, app_msi_req, app_msi_num,
    input  wb_ack, app_msi_ack
  );

  modport slave (
    input  wb_req, wb_addr, wb_data, app_msi_req, app_msi_num,
    output wb_ack, app_msi_ack
  );
endinterface

// File: rtl/sonic_irq_coalescer.sv
// Per-channel RX interrupt coalescing: threshold/timeout trigger, round-robin grant, writeback then MSI.
// Trigger to wb_req is 2 cycles; wb_req/app_msi_req hold until acked, so the host may stall indefinitely.
module sonic_irq_coalescer #(
  parameter int NUM_CH      = 4,
  parameter int PTR_WIDTH   = 16,
  parameter int TIMER_WIDTH = 16,
  parameter int USE_MSI     = 1
) (
  input  logic                        clk_in,
  input  logic                        rstn,
  input  logic                        init,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH*PTR_WIDTH-1:0] rx_ring_wptr,
  input  logic [NUM_CH*PTR_WIDTH-1:0] rx_block_size,
  input  logic [NUM_CH*PTR_WIDTH-1:0] rx_ring_size,
  input  logic [TIMER_WIDTH-1:0]      coal_timeout,
  input  logic [63:0]                 wb_base,
  input  logic                        msi_enable,
  sonic_irq_coalescer_if.master       bus,
  output logic                        busy
);
  localparam int PW1 = PTR_WIDTH + 1;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WB_REQ, MSI_REQ} state_t;
  state_t state, state_nxt;

  logic                             srst;
  logic [NUM_CH-1:0][PTR_WIDTH-1:0] wptr, blk_size, ring_size;
  logic [NUM_CH-1:0][PW1-1:0]       pending;
  logic [NUM_CH-1:0]                trig;
  logic [CW-1:0]                    ch, last_ch, grant_ch, rr_idx;
  logic                             grant_vld;
  logic [PW1-1:0]                   offset;
  logic [63:0]                      wb_addr_q, wb_data_q;
  logic                             serviced;

  assign srst      = !rstn || init;
  assign wptr      = rx_ring_wptr;
  assign blk_size  = rx_block_size;
  assign ring_size = rx_ring_size;
  assign serviced  = (state == WB_REQ) && bus.wb_ack;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PTR_WIDTH-1:0]   msi_ptr;
    logic [TIMER_WIDTH-1:0] timer;
    logic [PW1-1:0]         wp, mp, rs, bs, diff, sum, ptr_nxt;
    logic                   sel;

    assign sel  = (ch == CW'(i));
    assign wp   = PW1'(wptr[i]);
    assign mp   = PW1'(msi_ptr);
    assign rs   = PW1'(ring_size[i]);
    assign bs   = PW1'(blk_size[i]);
    // One extra bit keeps wp + rs from overflowing on the wrapped path.
    assign diff = (wp >= mp) ? (wp - mp) : (wp + rs - mp);
    assign pending[i] = {diff[PW1-1:2], 2'b00};
    assign trig[i] = ch_enable[i] && (pending[i] != '0) &&
                     (((bs != '0) && (pending[i] >= bs)) ||
                      ((coal_timeout != '0) && (timer >= coal_timeout)));

    assign sum     = mp + offset;
    assign ptr_nxt = (sum >= rs) ? (sum - rs) : sum;

    always_ff @(posedge clk_in) begin
      if (srst) begin
        msi_ptr <= '0;
      end else if (serviced && sel) begin
        msi_ptr <= ptr_nxt[PTR_WIDTH-1:0];
      end
    end

    always_ff @(posedge clk_in) begin
      if (srst) begin
        timer <= '0;
      end else if (!ch_enable[i] || (pending[i] == '0) || (serviced && sel)) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Walk from the highest priority offset down so the nearest channel after last_ch wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    rr_idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_idx = CW'((int'(last_ch) + 1 + k) % NUM_CH);
      if (trig[rr_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (srst) begin
      ch        <= '0;
      last_ch   <= CW'(NUM_CH - 1);
      offset    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (state == IDLE && grant_vld) ch <= grant_ch;
      if (state == GRANT) begin
        offset    <= pending[ch];
        wb_addr_q <= wb_base + (64'(ch) << 4);
        wb_data_q <= {8'(ch), 24'(pending[ch]), 32'(wptr[ch])};
      end
      if (serviced) last_ch <= ch;
    end
  end

  always_ff @(posedge clk_in) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.wb_req      = 1'b0;
    bus.app_msi_req = 1'b0;
    busy            = (state != IDLE);
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = GRANT;
      GRANT:   state_nxt = WB_REQ;
      WB_REQ: begin
        bus.wb_req = 1'b1;
        if (bus.wb_ack) state_nxt = ((USE_MSI != 0) && msi_enable) ? MSI_REQ : IDLE;
      end
      MSI_REQ: begin
        bus.app_msi_req = 1'b1;
        if (bus.app_msi_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.app_msi_num = 5'(ch);
endmodule

// File: doc/sonic_irq_coalescer.md
SONIC_IRQ_COALESCER -- requirements
Module: sonic_irq_coalescer

Interface
REQ-001 Parameter NUM_CH, default 4, number of RX ring channels; legal range 1..8.
REQ-002 Parameter PTR_WIDTH, default 16, width of ring pointers, sizes and offsets, in bytes.
REQ-003 Parameter TIMER_WIDTH, default 16, width of the per-channel coalescing timer.
REQ-004 Parameter USE_MSI, default 1; when 0, the MSI phase is skipped and app_msi_req is held at 0.
REQ-005 Port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-006 Port rstn, input, 1, reset; synchronous and active-low.
REQ-007 Port init, input, 1, software reset; synchronous, active-high, same effect as rstn.
REQ-008 Port ch_enable, input, NUM_CH, per-channel enable; bit i gates channel i.
REQ-009 Port rx_ring_wptr, input, NUM_CH*PTR_WIDTH, write pointer of each channel; channel i is in slice [i*PTR_WIDTH +: PTR_WIDTH].
REQ-010 Port rx_block_size, input, NUM_CH*PTR_WIDTH, per-channel byte threshold; 0 disables the threshold trigger.
REQ-011 Port rx_ring_size, input, NUM_CH*PTR_WIDTH, per-channel ring size in bytes; nonzero and a multiple of 4.
REQ-012 Port coal_timeout, input, TIMER_WIDTH, shared timeout in cycles; 0 disables the timeout trigger.
REQ-013 Port wb_base, input, 64, host base address of the writeback area.
REQ-014 Port msi_enable, input, 1, global MSI enable.
REQ-015 Port wb_req, output, 1, writeback request; held high until wb_ack is sampled.
REQ-016 Port wb_ack, input, 1, writeback accepted.
REQ-017 Port wb_addr, output, 64, writeback address, equal to wb_base + 16*ch.
REQ-018 Port wb_data, output, 64, writeback data: {8'(ch), 24'(offset), 32'(wptr snapshot)}, zero-extended.
REQ-019 Port app_msi_req, output, 1, MSI request; held high until app_msi_ack is sampled.
REQ-020 Port app_msi_ack, input, 1, MSI accepted.
REQ-021 Port app_msi_num, output, 5, MSI vector, equal to the serviced channel index.
REQ-022 Port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-023 Each channel i keeps a register msi_ptr[i]; pending[i] = wptr - msi_ptr when wptr >= msi_ptr, else wptr + ring_size - msi_ptr; bits [1:0] are forced to 0.
REQ-024 pending is computed in PTR_WIDTH+1 bits so the wrap sum cannot overflow.
REQ-025 Trigger[i] = ch_enable[i] AND pending[i] != 0 AND ((block_size[i] != 0 AND pending[i] >= block_size[i]) OR (coal_timeout != 0 AND timer[i] >= coal_timeout)).
REQ-026 timer[i] increments, saturating, each cycle pending[i] != 0 and ch_enable[i] = 1; it clears to 0 when pending[i] = 0, when ch_enable[i] = 0, or when channel i is serviced.
REQ-027 FSM states: IDLE, GRANT, WB_REQ, MSI_REQ.
REQ-028 IDLE -> GRANT when any trigger is high.
REQ-029 The grant is round-robin: the search starts at last_ch+1 modulo NUM_CH, and last_ch resets to NUM_CH-1, so channel 0 wins first.
REQ-030 GRANT latches ch, offset = pending[ch] and wptr_snap = wptr[ch], then moves unconditionally to WB_REQ; latency from trigger to wb_req is exactly 2 cycles.
REQ-031 WB_REQ asserts wb_req with stable addr/data. On wb_ack: msi_ptr[ch] <= (msi_ptr[ch] + offset) mod ring_size, computed with a single conditional subtract; timer[ch] clears; last_ch <= ch.
REQ-032 On that same wb_ack, the FSM moves to MSI_REQ if USE_MSI = 1 and msi_enable = 1, otherwise to IDLE.
REQ-033 MSI_REQ asserts app_msi_req with app_msi_num = ch; app_msi_ack returns the FSM to IDLE.
REQ-034 Pointer movement during service does not alter the latched offset; the unserviced remainder stays pending and may retrigger.
REQ-035 ch_enable[ch] falling mid-service does not abort the transaction.
REQ-036 wb_ack or app_msi_ack arriving outside its own state is ignored.
REQ-037 A channel receives at most one grant per service cycle; with all channels triggered, the grant order is 0,1,2,3,0,...

Reset
REQ-038 While rstn = 0 or init = 1 at a clock edge: FSM = IDLE; msi_ptr, timers and latched fields = 0; last_ch = NUM_CH-1; wb_req = 0, app_msi_req = 0, busy = 0, wb_addr = 0, wb_data = 0, app_msi_num = 0.
REQ-039 Reset or init in any state aborts the transaction with no msi_ptr update, and all outputs return to their reset values on the following cycle.

Verification
REQ-040 Threshold: ch0 ring 4096, block 256, wptr 0->300 -> wb_req 2 cycles later with wb_data = {8'h0, 24'd300 & ~3 = 300, 32'd300}, then MSI with vector 0; msi_ptr[0] = 300.
REQ-041 Wrap: ch1 ring 1024, msi_ptr 1000, wptr 40, block 32 -> offset 64, msi_ptr[1] = 40, wb_addr = base + 16.
REQ-042 Timeout: block 0, timeout 100, ch2 wptr 8 -> wb_req exactly 102 cycles after pending becomes nonzero; with timeout 0 there is no request ever.
REQ-043 Round-robin: ch0-3 all triggered simultaneously, acks immediate -> services ch0, ch1, ch2, ch3 in order; ch0 retriggering during ch1 service waits until after ch3.
REQ-044 msi_enable = 0 -> after wb_ack, IDLE with app_msi_req never asserted; with USE_MSI = 0, likewise.
REQ-045 rstn low for 1 cycle in WB_REQ -> wb_req = 0 the next cycle, msi_ptr unchanged (0), same trigger restarts from channel 0.
